// File: rtl/axi3_burst_slave.sv
// AXI3 slave backed by an internal word memory; INCR bursts only, 4-byte beats.
// Independent read and write FSMs, one outstanding transaction per direction.
module axi3_burst_slave #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic        AXI_clk,
    input  logic        rst,
    input  logic [31:0] AXI_awaddr,
    input  logic [5:0]  AXI_awid,
    input  logic [3:0]  AXI_awlen,
    input  logic        AXI_awvalid,
    output logic        AXI_awready,
    input  logic [31:0] AXI_wdata,
    input  logic [3:0]  AXI_wstrb,
    input  logic        AXI_wlast,
    input  logic        AXI_wvalid,
    output logic        AXI_wready,
    output logic [5:0]  AXI_bid,
    output logic [1:0]  AXI_bresp,
    output logic        AXI_bvalid,
    input  logic        AXI_bready,
    input  logic [31:0] AXI_araddr,
    input  logic [5:0]  AXI_arid,
    input  logic [3:0]  AXI_arlen,
    input  logic        AXI_arvalid,
    output logic        AXI_arready,
    output logic [31:0] AXI_rdata,
    output logic [5:0]  AXI_rid,
    output logic [1:0]  AXI_rresp,
    output logic        AXI_rlast,
    output logic        AXI_rvalid,
    input  logic        AXI_rready
);
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    logic [1:0]        w_state_q;
    logic [MEM_AW-1:0] w_idx_q;
    logic [3:0]        w_len_q;
    logic [3:0]        w_cnt_q;
    logic [5:0]        w_id_q;
    logic              w_err_q;
    logic              w_fire;
    logic              w_last_beat;

    logic [1:0]        r_state_q;
    logic [MEM_AW-1:0] r_idx_q;
    logic [3:0]        r_len_q;
    logic [3:0]        r_cnt_q;
    logic [5:0]        r_id_q;
    logic [31:0]       rdata_q;
    logic              rlast_q;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AXI_awaddr[31:MEM_AW+2], AXI_awaddr[1:0],
                                AXI_araddr[31:MEM_AW+2], AXI_araddr[1:0]};

    assign w_fire      = (w_state_q == W_DATA) && AXI_wvalid;
    assign w_last_beat = (w_cnt_q == w_len_q);

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_id_q    <= '0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (AXI_awvalid) begin
                        w_idx_q   <= AXI_awaddr[MEM_AW+1:2];
                        w_len_q   <= AXI_awlen;
                        w_id_q    <= AXI_awid;
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (AXI_wvalid) begin
                        w_idx_q <= w_idx_q + IDX_ONE;
                        w_cnt_q <= w_cnt_q + 4'd1;
                        // Beat count, not wlast, closes the burst; a misplaced wlast flags SLVERR.
                        if (w_last_beat) begin
                            w_state_q <= W_RESP;
                            if (!AXI_wlast) w_err_q <= 1'b1;
                        end else if (AXI_wlast) begin
                            w_err_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (AXI_bready) w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Memory is deliberately left out of reset; an aborted beat must not land.
    always_ff @(posedge AXI_clk) begin
        if (!rst && w_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (AXI_wstrb[i]) mem[w_idx_q][8*i +: 8] <= AXI_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_id_q    <= '0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (AXI_arvalid) begin
                        r_idx_q   <= AXI_araddr[MEM_AW+1:2];
                        r_len_q   <= AXI_arlen;
                        r_id_q    <= AXI_arid;
                        r_cnt_q   <= '0;
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // Non-blocking read of mem yields pre-write data on a same-cycle write.
                    rdata_q   <= mem[r_idx_q];
                    rlast_q   <= (r_cnt_q == r_len_q);
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (AXI_rready) begin
                        if (rlast_q) begin
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_idx_q   <= r_idx_q + IDX_ONE;
                            r_cnt_q   <= r_cnt_q + 4'd1;
                            r_state_q <= R_FETCH;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign AXI_awready = (w_state_q == W_IDLE);
    assign AXI_wready  = (w_state_q == W_DATA);
    assign AXI_bvalid  = (w_state_q == W_RESP);
    assign AXI_bid     = w_id_q;
    assign AXI_bresp   = ((w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;

    assign AXI_arready = (r_state_q == R_IDLE);
    assign AXI_rvalid  = (r_state_q == R_DATA);
    assign AXI_rdata   = rdata_q;
    assign AXI_rid     = r_id_q;
    assign AXI_rlast   = rlast_q;
    assign AXI_rresp   = 2'b00;

endmodule

// File: tb/tb_axi3_burst_slave.sv
// Directed bench for axi3_burst_slave: bursts, strobes, wlast errors, wrap,
// read backpressure with a concurrent write, and mid-burst reset.
module tb_axi3_burst_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr;
    logic [5:0]  awid, arid;
    logic [3:0]  awlen, wstrb, arlen;
    logic        awvalid, wlast, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [5:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wd [16];
    logic [31:0] rd [16];
    logic [5:0]  ri [16];
    logic        rl [16];

    always #5 clk = ~clk;

    axi3_burst_slave #(.MEM_AW(8)) dut (
        .AXI_clk(clk), .rst(rst),
        .AXI_awaddr(awaddr), .AXI_awid(awid), .AXI_awlen(awlen),
        .AXI_awvalid(awvalid), .AXI_awready(awready),
        .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wlast(wlast),
        .AXI_wvalid(wvalid), .AXI_wready(wready),
        .AXI_bid(bid), .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
        .AXI_araddr(araddr), .AXI_arid(arid), .AXI_arlen(arlen),
        .AXI_arvalid(arvalid), .AXI_arready(arready),
        .AXI_rdata(rdata), .AXI_rid(rid), .AXI_rresp(rresp), .AXI_rlast(rlast),
        .AXI_rvalid(rvalid), .AXI_rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks are entered at a negedge; ready is sampled there, ahead of the posedge.
    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                          output bit ok);
        int  g;
        logic rdy;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        ok = 1'b0;
        g  = 0;
        while (!ok && g < 50) begin
            rdy = wready;
            @(negedge clk);
            g++;
            ok = rdy;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic aw_req(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len);
        int  g;
        bit  hs;
        logic rdy;
        awaddr = a; awid = id; awlen = len; awvalid = 1'b1;
        hs = 1'b0;
        g  = 0;
        while (!hs && g < 50) begin
            rdy = awready;
            @(negedge clk);
            g++;
            hs = rdy;
        end
        awvalid = 1'b0;
        check("aw_handshake", {31'd0, hs}, 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                             input logic [3:0] s, input int last_beat,
                             output logic [1:0] resp, output logic [5:0] bid_o,
                             output int beats);
        int g;
        bit ok;
        aw_req(a, id, len);
        beats = 0;
        for (int b = 0; b <= int'(len); b++) begin
            w_beat(wd[b], s, (b == last_beat), ok);
            if (ok) beats++;
        end
        check("wready_low_after_burst", {31'd0, wready}, 32'd0);
        g = 0;
        while (!bvalid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("bvalid_seen", {31'd0, bvalid}, 32'd1);
        resp  = bresp;
        bid_o = bid;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                            input int stall_beat);
        int  g;
        bit  hs;
        logic rdy;
        araddr = a; arid = id; arlen = len; arvalid = 1'b1;
        hs = 1'b0;
        g  = 0;
        while (!hs && g < 50) begin
            rdy = arready;
            @(negedge clk);
            g++;
            hs = rdy;
        end
        arvalid = 1'b0;
        check("ar_handshake", {31'd0, hs}, 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            g = 0;
            while (!rvalid && g < 50) begin
                @(negedge clk);
                g++;
            end
            // One idle sample (R_FETCH) then rvalid: two cycles after the handshake.
            check("r_latency", g, 32'd1);
            rd[b] = rdata; ri[b] = rid; rl[b] = rlast;
            if (b == stall_beat) begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_rvalid", {31'd0, rvalid}, 32'd1);
                    check("stall_rdata", rdata, rd[b]);
                    check("stall_rid", {26'd0, rid}, {26'd0, ri[b]});
                    check("stall_rlast", {31'd0, rlast}, {31'd0, rl[b]});
                end
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
    endtask

    task automatic expect_read(input string tag, input logic [3:0] len, input logic [5:0] id,
                               input logic [31:0] exp0, input logic [31:0] exp1,
                               input logic [31:0] exp2, input logic [31:0] exp3);
        logic [31:0] e [4];
        e[0] = exp0; e[1] = exp1; e[2] = exp2; e[3] = exp3;
        for (int b = 0; b <= int'(len); b++) begin
            check({tag, "_data"}, rd[b], e[b]);
            check({tag, "_rlast"}, {31'd0, rl[b]}, {31'd0, (b == int'(len))});
            check({tag, "_rid"}, {26'd0, ri[b]}, {26'd0, id});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] resp;
        logic [5:0] b_id;
        int         beats;
        bit         ok;

        rst = 1'b1;
        awaddr = '0; awid = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rlast", {31'd0, rlast}, 32'd0);
        check("rst_bid", {26'd0, bid}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        check("rst_rid", {26'd0, rid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", {30'd0, rresp}, 32'd0);

        // 16-beat write then read back.
        for (int i = 0; i < 16; i++) wd[i] = i;
        axi_write(32'h100, 6'h3F, 4'hF, 4'hF, 15, resp, b_id, beats);
        check("b16_bresp", {30'd0, resp}, 32'd0);
        check("b16_bid", {26'd0, b_id}, 32'h3F);
        check("b16_beats", beats, 32'd16);
        axi_read(32'h100, 6'h3F, 4'hF, -1);
        for (int b = 0; b < 16; b++) begin
            check("b16_rdata", rd[b], b);
            check("b16_rlast", {31'd0, rl[b]}, {31'd0, (b == 15)});
            check("b16_rid", {26'd0, ri[b]}, 32'h3F);
        end

        // Byte strobes.
        wd[0] = 32'h11223344;
        axi_write(32'h40, 6'h01, 4'h0, 4'hF, 0, resp, b_id, beats);
        wd[0] = 32'hAABBCCDD;
        axi_write(32'h40, 6'h02, 4'h0, 4'b0101, 0, resp, b_id, beats);
        check("strb_bresp", {30'd0, resp}, 32'd0);
        check("strb_bid", {26'd0, b_id}, 32'h02);
        axi_read(32'h40, 6'h07, 4'h0, -1);
        expect_read("strb", 4'h0, 6'h07, 32'h11BB33DD, 32'h0, 32'h0, 32'h0);

        // Early wlast: all four beats still taken, SLVERR reported.
        for (int i = 0; i < 4; i++) wd[i] = 32'hE000_0000 + i;
        axi_write(32'h80, 6'h15, 4'h3, 4'hF, 1, resp, b_id, beats);
        check("early_wlast_beats", beats, 32'd4);
        check("early_wlast_bresp", {30'd0, resp}, 32'h2);
        check("early_wlast_bid", {26'd0, b_id}, 32'h15);

        // Missing wlast also errors.
        axi_write(32'h80, 6'h16, 4'h3, 4'hF, -1, resp, b_id, beats);
        check("no_wlast_bresp", {30'd0, resp}, 32'h2);

        // Wrap at the top of the word space.
        for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE_0000 + i;
        axi_write(32'h3F8, 6'h09, 4'h3, 4'hF, 3, resp, b_id, beats);
        check("wrap_bresp", {30'd0, resp}, 32'd0);
        axi_read(32'h3F8, 6'h0A, 4'h3, -1);
        expect_read("wrap", 4'h3, 6'h0A, 32'hC0DE0000, 32'hC0DE0001,
                    32'hC0DE0002, 32'hC0DE0003);
        axi_read(32'h000, 6'h0B, 4'h0, -1);
        expect_read("wrap_word0", 4'h0, 6'h0B, 32'hC0DE0002, 32'h0, 32'h0, 32'h0);

        // Read backpressure with a concurrent write burst.
        for (int i = 0; i < 4; i++) wd[i] = 32'h5000_0000 + i;
        fork
            axi_read(32'h100, 6'h21, 4'hF, 5);
            begin
                logic [1:0] c_resp;
                logic [5:0] c_bid;
                int         c_beats;
                repeat (2) @(negedge clk);
                axi_write(32'h300, 6'h22, 4'h3, 4'hF, 3, c_resp, c_bid, c_beats);
                check("conc_bresp", {30'd0, c_resp}, 32'd0);
                check("conc_bid", {26'd0, c_bid}, 32'h22);
                check("conc_beats", c_beats, 32'd4);
            end
        join
        for (int b = 0; b < 16; b++) begin
            check("stall_rd_data", rd[b], b);
            check("stall_rd_rlast", {31'd0, rl[b]}, {31'd0, (b == 15)});
        end
        axi_read(32'h300, 6'h23, 4'h3, -1);
        expect_read("conc", 4'h3, 6'h23, 32'h50000000, 32'h50000001,
                    32'h50000002, 32'h50000003);

        // Reset during beat 5 of an 8-beat write.
        for (int i = 0; i < 8; i++) wd[i] = 32'hA0 + i;
        aw_req(32'h200, 6'h05, 4'h7);
        for (int b = 0; b < 4; b++) w_beat(wd[b], 4'hF, 1'b0, ok);
        wdata = wd[4]; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wvalid = 1'b0;
        check("abort_awready", {31'd0, awready}, 32'd1);
        check("abort_bvalid", {31'd0, bvalid}, 32'd0);
        check("abort_wready", {31'd0, wready}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_bvalid_later", {31'd0, bvalid}, 32'd0);
        axi_read(32'h200, 6'h06, 4'h3, -1);
        expect_read("abort", 4'h3, 6'h06, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi3_burst_slave.md
AXI3_BURST_SLAVE -- requirements
Module: axi3_burst_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning log2 of internal memory depth in 32-bit words.
REQ-002 SHALL have port AXI_clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port AXI_awaddr  input  32  write burst byte address.
REQ-005 SHALL have port AXI_awid  input  6  write transaction ID.
REQ-006 SHALL have port AXI_awlen  input  4  write beats minus 1.
REQ-007 SHALL have port AXI_awvalid  input  1  write address valid.
REQ-008 SHALL have port AXI_awready  output  1  write address accepted.
REQ-009 SHALL have port AXI_wdata  input  32  write beat data.
REQ-010 SHALL have port AXI_wstrb  input  4  byte enables for AXI_wdata.
REQ-011 SHALL have port AXI_wlast  input  1  final write beat marker.
REQ-012 SHALL have port AXI_wvalid  input  1  write data valid.
REQ-013 SHALL have port AXI_wready  output  1  write data accepted.
REQ-014 SHALL have port AXI_bid  output  6  write response ID.
REQ-015 SHALL have port AXI_bresp  output  2  write response: 00 OKAY, 10 SLVERR.
REQ-016 SHALL have port AXI_bvalid  output  1  write response valid.
REQ-017 SHALL have port AXI_bready  input  1  write response accepted.
REQ-018 SHALL have port AXI_araddr  input  32  read burst byte address.
REQ-019 SHALL have port AXI_arid  input  6  read transaction ID.
REQ-020 SHALL have port AXI_arlen  input  4  read beats minus 1.
REQ-021 SHALL have port AXI_arvalid  input  1  read address valid.
REQ-022 SHALL have port AXI_arready  output  1  read address accepted.
REQ-023 SHALL have port AXI_rdata  output  32  read beat data.
REQ-024 SHALL have port AXI_rid  output  6  read beat ID.
REQ-025 SHALL have port AXI_rresp  output  2  read response; always 00.
REQ-026 SHALL have port AXI_rlast  output  1  final read beat marker.
REQ-027 SHALL have port AXI_rvalid  output  1  read data valid.
REQ-028 SHALL have port AXI_rready  input  1  read data accepted.

Function
REQ-029 SHALL treat every burst as INCR with 4-byte beats; word index = addr[MEM_AW+1:2], incremented by 1 per beat, wrapping modulo 2^MEM_AW; addr[1:0] and upper address bits are ignored.
REQ-030 SHALL run the write FSM as W_IDLE -> W_DATA -> W_RESP -> W_IDLE; AXI_awready=1 only in W_IDLE.
REQ-031 SHALL, on the AW handshake, capture the word index, awlen and awid, clear the beat counter and error flag, and enter W_DATA.
REQ-032 SHALL hold AXI_wready=1 only in W_DATA; each W handshake writes each byte lane whose wstrb bit is 1 and increments the address and beat counter.
REQ-033 SHALL end the burst on beat awlen+1 regardless of AXI_wlast, and set the error flag if wlast is 0 on that beat or 1 on any earlier beat.
REQ-034 SHALL, in W_RESP, drive AXI_bvalid=1, AXI_bid=captured ID, and AXI_bresp=10 if the error flag is set, else 00; all held stable until AXI_bready, then return to W_IDLE.
REQ-035 SHALL run the read FSM as R_IDLE -> R_FETCH -> R_DATA; AXI_arready=1 only in R_IDLE.
REQ-036 SHALL, on the AR handshake, capture the word index, arlen and arid; R_FETCH registers mem[index] into AXI_rdata; R_DATA drives AXI_rvalid=1 with AXI_rid=captured ID.
REQ-037 SHALL produce the first AXI_rvalid 2 cycles after the AR handshake and each later beat 2 cycles after the previous R handshake.
REQ-038 SHALL assert AXI_rlast on beat arlen+1; rdata, rid and rlast SHALL be stable while rvalid=1 and rready=0.
REQ-039 SHALL, on the R handshake, go to R_IDLE if rlast=1, else to R_FETCH with index+1.
REQ-040 SHALL run the read and write FSMs independently and concurrently; with one transaction outstanding per direction, a new AW or AR is not accepted until the previous one completes.
REQ-041 SHALL, when a write and an R_FETCH hit the same word in the same cycle, return the pre-write data (read-before-write).

Reset
REQ-042 SHALL, on rst=1 at a clock edge, put both FSMs in their IDLE states with AXI_awready=1, AXI_arready=1, AXI_wready=0, AXI_bvalid=0, AXI_rvalid=0, AXI_rlast=0, and AXI_bid, AXI_bresp, AXI_rid, AXI_rdata, AXI_rresp all 0.
REQ-043 SHALL abort any in-progress burst when reset is applied mid-burst, without issuing a response; memory contents SHALL NOT be reset.

Verification
REQ-044 SHALL pass: write 16 beats (awaddr 0x100, awlen 0xF, awid 0x3F, data 0..15, wlast on beat 16) -> bresp 00, bid 0x3F; then read the same burst -> data 0..15, rlast only on beat 16, rid 0x3F.
REQ-045 SHALL pass: single write, wstrb 0101, data 0xAABBCCDD over 0x11223344 -> read back 0x11BB33DD.
REQ-046 SHALL pass: awlen 3 with wlast on beat 2 -> 4 beats accepted, then bresp 10.
REQ-047 SHALL pass: MEM_AW 8, read at word 254 with arlen 3 -> words 254, 255, 0, 1 returned in that order.
REQ-048 SHALL pass: rready held low for 5 cycles mid-burst -> rdata, rid and rlast held constant; concurrent write burst completes unaffected.
REQ-049 SHALL pass: rst pulsed during beat 5 of a write -> no bvalid, awready=1 on the cycle after reset, and beats 1-4 remain in memory.
